// File: rtl/ctm_pkg.sv
// Shared types and constants for the commit trace monitor.
package ctm_pkg;

    localparam int INSTR_W = 32;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_PC   = 2'd1;
    localparam logic [1:0] CAUSE_LOOP = 2'd2;
    localparam logic [1:0] CAUSE_WDOG = 2'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        DUMP   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // A trace entry is {pc, instr}.
    function automatic int entry_w(input int xlen);
        return xlen + INSTR_W;
    endfunction

endpackage

// File: rtl/ctm_trace_ring.sv
// Circular commit trace: DEPTH x {pc, instr} with saturating fill count
// and an oldest-first read pointer for the post-halt dump.
module ctm_trace_ring
    import ctm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [XLEN-1:0]    wr_pc_i,
    input  logic [INSTR_W-1:0] wr_instr_i,
    input  logic               rd_load_i,
    input  logic               rd_adv_i,
    output logic [CW-1:0]      count_o,
    output logic [XLEN-1:0]    rd_pc_o,
    output logic [INSTR_W-1:0] rd_instr_o,
    output logic               rd_last_o
);

    localparam int EW = entry_w(XLEN);

    logic [EW-1:0] ram_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] rd_idx_q;
    logic [AW-1:0] oldest;
    logic [AW-1:0] rd_sel;
    logic [CW-1:0] rd_sel_idx;

    // When full, count's low bits are zero, so oldest lands on wptr.
    assign oldest     = wptr_q - count_q[AW-1:0];
    assign rd_sel     = rd_load_i ? oldest : rd_ptr_q;
    assign rd_sel_idx = rd_load_i ? '0 : rd_idx_q;

    assign {rd_pc_o, rd_instr_o} = ram_q[rd_sel];
    assign rd_last_o = (rd_sel_idx == count_q - CW'(1));
    assign count_o   = count_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            ram_q[wptr_q] <= {wr_pc_i, wr_instr_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wptr_q   <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            rd_idx_q <= '0;
        end else begin
            if (wr_en_i) begin
                wptr_q <= wptr_q + AW'(1);
                if (count_q != CW'(DEPTH)) begin
                    count_q <= count_q + CW'(1);
                end
            end
            if (rd_load_i) begin
                rd_ptr_q <= oldest + AW'(1);
                rd_idx_q <= CW'(1);
            end else if (rd_adv_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                rd_idx_q <= rd_idx_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/commit_trace_monitor.sv
// Run-control monitor on the commit stage: counters, halt detection and
// oldest-first trace dump over a valid/ready port.
//   state  | meaning
//   RUN    | counting commits, watching for halt conditions
//   HALTED | halt seen, waiting for dump_start
//   DUMP   | streaming trace entries oldest first
//   DONE   | dump finished, idle until reset
module commit_trace_monitor
    import ctm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 32,
    parameter int SELF_LOOP_N = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   commit_valid,
    input  logic [XLEN-1:0]        commit_pc,
    input  logic [INSTR_W-1:0]     commit_instr,
    input  logic                   halt_pc_en,
    input  logic [XLEN-1:0]        halt_pc,
    input  logic                   dump_start,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [XLEN-1:0]        dump_pc,
    output logic [INSTR_W-1:0]     dump_instr,
    output logic                   dump_last,
    output logic                   halted,
    output logic [1:0]             halt_cause,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       instret_cnt,
    output logic [$clog2(DEPTH):0] trace_count
);

    localparam int LW = $clog2(SELF_LOOP_N + 1);
    localparam int WW = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t               state_q, state_d;
    logic [1:0]           cause_q, cause_d;
    logic [CNT_W-1:0]     cycle_q, cycle_d;
    logic [CNT_W-1:0]     instret_q, instret_d;
    logic [XLEN-1:0]      prev_pc_q, prev_pc_d;
    logic [LW-1:0]        loop_q, loop_d;
    logic [WW-1:0]        wdog_q, wdog_d;
    logic                 dvalid_q, dvalid_d;
    logic [XLEN-1:0]      dpc_q, dpc_d;
    logic [INSTR_W-1:0]   dinstr_q, dinstr_d;
    logic                 dlast_q, dlast_d;

    logic                 in_run, commit_go;
    logic                 pc_hit, loop_hit, wdog_hit;
    logic [LW-1:0]        loop_next;
    logic                 rd_load, rd_adv, rd_last;
    logic [XLEN-1:0]      rd_pc;
    logic [INSTR_W-1:0]   rd_instr;

    assign in_run    = (state_q == RUN);
    assign commit_go = in_run && commit_valid;

    // loop_q == 0 means no commit since reset, so there is no previous PC.
    always_comb begin
        loop_next = LW'(1);
        if (loop_q != '0 && commit_pc == prev_pc_q) begin
            loop_next = (loop_q == LW'(SELF_LOOP_N)) ? loop_q : loop_q + LW'(1);
        end
    end

    assign pc_hit   = commit_go && halt_pc_en && (commit_pc == halt_pc);
    assign loop_hit = commit_go && (loop_next == LW'(SELF_LOOP_N));
    assign wdog_hit = (WDOG_CYCLES != 0) && in_run && !commit_valid
                      && (wdog_q == WW'(WDOG_CYCLES - 1));

    ctm_trace_ring #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk        (clk),
        .rst_i      (rstn),
        .wr_en_i    (commit_go),
        .wr_pc_i    (commit_pc),
        .wr_instr_i (commit_instr),
        .rd_load_i  (rd_load),
        .rd_adv_i   (rd_adv),
        .count_o    (trace_count),
        .rd_pc_o    (rd_pc),
        .rd_instr_o (rd_instr),
        .rd_last_o  (rd_last)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        prev_pc_d = prev_pc_q;
        loop_d    = loop_q;
        wdog_d    = wdog_q;
        dvalid_d  = dvalid_q;
        dpc_d     = dpc_q;
        dinstr_d  = dinstr_q;
        dlast_d   = dlast_q;
        rd_load   = 1'b0;
        rd_adv    = 1'b0;

        unique case (state_q)
            RUN: begin
                if (cycle_q != CNT_MAX) cycle_d = cycle_q + CNT_W'(1);
                if (commit_valid) begin
                    if (instret_q != CNT_MAX) instret_d = instret_q + CNT_W'(1);
                    prev_pc_d = commit_pc;
                    loop_d    = loop_next;
                    wdog_d    = '0;
                end else if (WDOG_CYCLES != 0 && wdog_q != WW'(WDOG_CYCLES)) begin
                    wdog_d = wdog_q + WW'(1);
                end
                if (pc_hit) begin
                    cause_d = CAUSE_PC;
                end else if (loop_hit) begin
                    cause_d = CAUSE_LOOP;
                end else if (wdog_hit) begin
                    cause_d = CAUSE_WDOG;
                end
                if (pc_hit || loop_hit || wdog_hit) state_d = HALTED;
            end
            HALTED: begin
                if (dump_start) begin
                    if (trace_count != '0) begin
                        state_d  = DUMP;
                        rd_load  = 1'b1;
                        dvalid_d = 1'b1;
                        dpc_d    = rd_pc;
                        dinstr_d = rd_instr;
                        dlast_d  = rd_last;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DUMP: begin
                if (dvalid_q && dump_ready) begin
                    if (dlast_q) begin
                        state_d  = DONE;
                        dvalid_d = 1'b0;
                        dlast_d  = 1'b0;
                    end else begin
                        rd_adv   = 1'b1;
                        dpc_d    = rd_pc;
                        dinstr_d = rd_instr;
                        dlast_d  = rd_last;
                    end
                end
            end
            DONE: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= RUN;
            cause_q   <= CAUSE_NONE;
            cycle_q   <= '0;
            instret_q <= '0;
            prev_pc_q <= '0;
            loop_q    <= '0;
            wdog_q    <= '0;
            dvalid_q  <= 1'b0;
            dpc_q     <= '0;
            dinstr_q  <= '0;
            dlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            prev_pc_q <= prev_pc_d;
            loop_q    <= loop_d;
            wdog_q    <= wdog_d;
            dvalid_q  <= dvalid_d;
            dpc_q     <= dpc_d;
            dinstr_q  <= dinstr_d;
            dlast_q   <= dlast_d;
        end
    end

    assign halted      = (state_q != RUN);
    assign halt_cause  = cause_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign dump_valid  = dvalid_q;
    assign dump_pc     = dpc_q;
    assign dump_instr  = dinstr_q;
    assign dump_last   = dlast_q;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Scoreboard bench: stimulus queues expected dump entries, a negedge monitor
// pops them on each handshake; status outputs are checked directly.
module tb_commit_trace_monitor;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        last;
    } entry_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_instr;
    logic        halt_pc_en;
    logic [31:0] halt_pc;
    logic        dump_start;
    logic        dump_ready;

    logic        dump_valid, dump_last, halted;
    logic [31:0] dump_pc, dump_instr;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_cnt, instret_cnt;
    logic [4:0]  trace_count;

    logic        s_dump_valid, s_dump_last, s_halted;
    logic [31:0] s_dump_pc, s_dump_instr;
    logic [1:0]  s_halt_cause;
    logic [3:0]  s_cycle_cnt, s_instret_cnt;
    logic [4:0]  s_trace_count;

    int n_total = 0;
    int n_pass  = 0;
    entry_t exp_q[$];

    logic        stall_chk = 1'b0;
    logic [31:0] held_pc, held_instr;
    logic        held_last;

    always #5 clk = ~clk;

    commit_trace_monitor #(
        .XLEN(32), .DEPTH(16), .CNT_W(32), .SELF_LOOP_N(4), .WDOG_CYCLES(8)
    ) u_dut (
        .clk(clk), .rstn(rstn),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .halt_pc_en(halt_pc_en), .halt_pc(halt_pc), .dump_start(dump_start),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_pc(dump_pc),
        .dump_instr(dump_instr), .dump_last(dump_last), .halted(halted),
        .halt_cause(halt_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
        .trace_count(trace_count)
    );

    commit_trace_monitor #(
        .XLEN(32), .DEPTH(16), .CNT_W(4), .SELF_LOOP_N(4), .WDOG_CYCLES(8)
    ) u_sat (
        .clk(clk), .rstn(rstn),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .halt_pc_en(halt_pc_en), .halt_pc(halt_pc), .dump_start(dump_start),
        .dump_valid(s_dump_valid), .dump_ready(dump_ready), .dump_pc(s_dump_pc),
        .dump_instr(s_dump_instr), .dump_last(s_dump_last), .halted(s_halted),
        .halt_cause(s_halt_cause), .cycle_cnt(s_cycle_cnt), .instret_cnt(s_instret_cnt),
        .trace_count(s_trace_count)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endfunction

    function automatic logic [31:0] mk_ins(input logic [31:0] pc);
        return {pc[19:0], 12'h013};
    endfunction

    function automatic void push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic last);
        entry_t e;
        e.pc = pc; e.instr = instr; e.last = last;
        exp_q.push_back(e);
    endfunction

    // Monitor: samples on negedge, away from the active edge.
    always @(negedge clk) begin
        if (stall_chk) begin
            chk("stall_valid", {63'd0, dump_valid}, 64'd1);
            chk("stall_pc", {32'd0, dump_pc}, {32'd0, held_pc});
            chk("stall_instr", {32'd0, dump_instr}, {32'd0, held_instr});
            chk("stall_last", {63'd0, dump_last}, {63'd0, held_last});
        end
        stall_chk = 1'b0;
        if (!rstn && dump_valid && !dump_ready) begin
            stall_chk  = 1'b1;
            held_pc    = dump_pc;
            held_instr = dump_instr;
            held_last  = dump_last;
        end
        if (!rstn && dump_valid && dump_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_entry: got pc 0x%0h, required no entry", dump_pc);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                chk("sb_pc", {32'd0, dump_pc}, {32'd0, e.pc});
                chk("sb_instr", {32'd0, dump_instr}, {32'd0, e.instr});
                chk("sb_last", {63'd0, dump_last}, {63'd0, e.last});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b1; commit_valid = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        tick();
        rstn = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] instr);
        commit_valid = 1'b1; commit_pc = pc; commit_instr = instr;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic run_dump(input bit backpressure, input int budget);
        int k;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        k = 0;
        while (dump_valid && k < budget) begin
            dump_ready = backpressure ? (k % 3 == 0) : 1'b1;
            tick();
            k++;
        end
        dump_ready = 1'b0;
        chk("dump_finished", {63'd0, dump_valid}, 64'd0);
        chk("sb_drained", exp_q.size(), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_instr = '0;
        halt_pc_en = 1'b0; halt_pc = '0; dump_start = 1'b0; dump_ready = 1'b0;

        // Reset state, then reset mid-run.
        do_reset();
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_cause", {62'd0, halt_cause}, 64'd0);
        chk("rst_cycle", {32'd0, cycle_cnt}, 64'd0);
        chk("rst_instret", {32'd0, instret_cnt}, 64'd0);
        chk("rst_trace", {59'd0, trace_count}, 64'd0);
        chk("rst_dvalid", {63'd0, dump_valid}, 64'd0);
        for (int i = 0; i < 5; i++) commit(32'h100 + 4 * i, mk_ins(32'h100 + 4 * i));
        chk("run5_instret", {32'd0, instret_cnt}, 64'd5);
        chk("run5_cycle", {32'd0, cycle_cnt}, 64'd5);
        do_reset();
        chk("mid_rst_instret", {32'd0, instret_cnt}, 64'd0);
        chk("mid_rst_cycle", {32'd0, cycle_cnt}, 64'd0);
        chk("mid_rst_trace", {59'd0, trace_count}, 64'd0);
        commit(32'h200, mk_ins(32'h200));
        chk("post_rst_instret", {32'd0, instret_cnt}, 64'd1);
        chk("post_rst_trace", {59'd0, trace_count}, 64'd1);

        // PC-match halt, later commits ignored, plain dump.
        do_reset();
        halt_pc_en = 1'b1; halt_pc = 32'hFF;
        for (int i = 0; i < 8; i++) begin
            commit(4 * i, mk_ins(4 * i));
            chk("pcm_not_halted", {63'd0, halted}, 64'd0);
        end
        commit(32'hFF, mk_ins(32'hFF));
        chk("pcm_halted", {63'd0, halted}, 64'd1);
        chk("pcm_cause", {62'd0, halt_cause}, 64'd1);
        chk("pcm_instret", {32'd0, instret_cnt}, 64'd9);
        chk("pcm_trace", {59'd0, trace_count}, 64'd9);
        chk("pcm_cycle", {32'd0, cycle_cnt}, 64'd9);
        commit(32'h300, mk_ins(32'h300));
        commit(32'h304, mk_ins(32'h304));
        chk("pcm_ignored_instret", {32'd0, instret_cnt}, 64'd9);
        chk("pcm_ignored_trace", {59'd0, trace_count}, 64'd9);
        chk("pcm_frozen_cycle", {32'd0, cycle_cnt}, 64'd9);
        halt_pc_en = 1'b0;
        for (int i = 0; i < 8; i++) push_exp(4 * i, mk_ins(4 * i), 1'b0);
        push_exp(32'hFF, mk_ins(32'hFF), 1'b1);
        run_dump(1'b0, 40);

        // Self-loop halt with a wrapped ring, dumped under backpressure.
        do_reset();
        for (int i = 0; i < 20; i++) commit(32'h1000 + 4 * i, mk_ins(32'h1000 + 4 * i));
        for (int k = 0; k < 4; k++) commit(32'h60, 32'h13 + (k << 7));
        chk("loop_halted", {63'd0, halted}, 64'd1);
        chk("loop_cause", {62'd0, halt_cause}, 64'd2);
        chk("loop_instret", {32'd0, instret_cnt}, 64'd24);
        chk("loop_trace", {59'd0, trace_count}, 64'd16);
        chk("loop_cycle", {32'd0, cycle_cnt}, 64'd24);
        for (int i = 8; i < 20; i++) push_exp(32'h1000 + 4 * i, mk_ins(32'h1000 + 4 * i), 1'b0);
        for (int k = 0; k < 4; k++) push_exp(32'h60, 32'h13 + (k << 7), k == 3);
        run_dump(1'b1, 100);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        chk("done_ignores_start", {63'd0, dump_valid}, 64'd0);
        chk("done_halted", {63'd0, halted}, 64'd1);

        // Reset abandons a stalled dump.
        do_reset();
        halt_pc_en = 1'b1; halt_pc = 32'h40;
        commit(32'h40, mk_ins(32'h40));
        halt_pc_en = 1'b0;
        chk("abort_halted", {63'd0, halted}, 64'd1);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("abort_dvalid_up", {63'd0, dump_valid}, 64'd1);
        chk("abort_first_pc", {32'd0, dump_pc}, 64'h40);
        chk("abort_first_last", {63'd0, dump_last}, 64'd1);
        tick();
        do_reset();
        chk("abort_dvalid_down", {63'd0, dump_valid}, 64'd0);
        chk("abort_unhalted", {63'd0, halted}, 64'd0);

        // Watchdog fires exactly WDOG_CYCLES idle cycles after the last commit.
        do_reset();
        commit(32'h2000, mk_ins(32'h2000));
        for (int i = 0; i < 7; i++) tick();
        chk("wdog_not_yet", {63'd0, halted}, 64'd0);
        tick();
        chk("wdog_halted", {63'd0, halted}, 64'd1);
        chk("wdog_cause", {62'd0, halt_cause}, 64'd3);
        chk("wdog_cycle", {32'd0, cycle_cnt}, 64'd9);
        chk("wdog_instret", {32'd0, instret_cnt}, 64'd1);
        chk("wdog_trace", {59'd0, trace_count}, 64'd1);
        push_exp(32'h2000, mk_ins(32'h2000), 1'b1);
        run_dump(1'b1, 20);

        // PC match outranks a simultaneous self-loop.
        do_reset();
        for (int k = 0; k < 3; k++) commit(32'h300, 32'h13);
        chk("sim_not_halted", {63'd0, halted}, 64'd0);
        halt_pc_en = 1'b1; halt_pc = 32'h300;
        commit(32'h300, 32'h13);
        halt_pc_en = 1'b0;
        chk("sim_cause", {62'd0, halt_cause}, 64'd1);

        // Counter saturation on the narrow instance; dump_start in RUN ignored.
        do_reset();
        for (int i = 0; i < 20; i++) commit(32'h4000 + 4 * i, mk_ins(32'h4000 + 4 * i));
        chk("sat_cycle", {60'd0, s_cycle_cnt}, 64'd15);
        chk("sat_instret", {60'd0, s_instret_cnt}, 64'd15);
        chk("wide_instret", {32'd0, instret_cnt}, 64'd20);
        chk("sat_not_halted", {63'd0, s_halted}, 64'd0);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("run_ignores_start", {63'd0, dump_valid}, 64'd0);
        chk("run_stays_run", {63'd0, halted}, 64'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
